// File: rtl/fairy_memory_stage.sv
// Purpose : MIPS-style memory stage: decodes loads/stores, drives a req/gnt + rvalid data port, registers the writeback payload.
// Latency : non-memory/faulting ops 1 cycle; stores 1 cycle after gnt; loads 1 cycle after rvalid.
// Backpr. : ex_ready_o only in IDLE; request held stable until dmem_gnt_i; at most one outstanding load.
//
// Ports   : clk/reset_n (async active-low); ex_* handshake + instruction fields from execute;
//           flush_i kills in-flight work; dmem_* request/grant/response port; *_o registered writeback payload.
// Config  : define FAIRY_MEM_UNALIGNED_CHECK_EN to enable misaligned-address detection
//           (LH/LHU/SH odd address, LW/SW not word aligned); otherwise unaligned_addr_o stays 0.
module fairy_memory_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic        overflow_i,
    input  logic        illegal_inst_i,
    input  logic        delayslot_i,
    input  logic        hilo_we_i,
    input  logic        hilo_sel_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] data_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic        overflow_o,
    output logic        unaligned_addr_o,
    output logic        illegal_inst_o,
    output logic        delayslot_o,
    output logic        hilo_we_o,
    output logic        hilo_sel_o
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_e;

    // Registered writeback payload; all-zero is the bubble (inst 0 = NOP).
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic        reg_we;
        logic        overflow;
        logic        unaligned;
        logic        illegal;
        logic        delayslot;
        logic        hilo_we;
        logic        hilo_sel;
    } wb_t;

    // Memory instruction held while the request/response is in flight.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  waddr;
        logic        reg_we;
        logic        delayslot;
        logic        hilo_we;
        logic        hilo_sel;
    } lat_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_e state_q, state_d;
    wb_t    wb_q, wb_d;
    lat_t   lat_q, lat_d;

    logic [5:0] op_in;
    logic [5:0] op_lat;
    logic       mem_in;
    logic       unal_in;
    logic       lat_is_load;
    wb_t        mem_wb;

    assign op_in       = inst_i[31:26];
    assign op_lat      = lat_q.inst[31:26];
    assign mem_in      = is_load(op_in) || is_store(op_in);
    assign lat_is_load = is_load(op_lat);

`ifdef FAIRY_MEM_UNALIGNED_CHECK_EN
    always_comb begin
        unal_in = 1'b0;
        case (op_in)
            OP_LH, OP_LHU, OP_SH: unal_in = alu_result_i[0];
            OP_LW, OP_SW:         unal_in = (alu_result_i[1:0] != 2'b00);
            default:              unal_in = 1'b0;
        endcase
    end
`else
    assign unal_in = 1'b0;
`endif

    // Writeback record of the latched memory op; data and reg_we are filled per completion type.
    always_comb begin
        mem_wb           = '0;
        mem_wb.inst      = lat_q.inst;
        mem_wb.pc        = lat_q.pc;
        mem_wb.waddr     = lat_q.waddr;
        mem_wb.delayslot = lat_q.delayslot;
        mem_wb.hilo_we   = lat_q.hilo_we;
        mem_wb.hilo_sel  = lat_q.hilo_sel;
    end

    always_comb begin
        state_d = state_q;
        wb_d    = '0;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (ex_valid_i && !flush_i) begin
                    if (!mem_in || overflow_i || illegal_inst_i || unal_in) begin
                        // Completes here without touching memory; a misaligned access
                        // reports the faulting address and must not write a register.
                        wb_d.data      = alu_result_i;
                        wb_d.inst      = inst_i;
                        wb_d.pc        = pc_i;
                        wb_d.waddr     = reg_waddr_i;
                        wb_d.reg_we    = reg_we_i && !unal_in;
                        wb_d.overflow  = overflow_i;
                        wb_d.unaligned = unal_in;
                        wb_d.illegal   = illegal_inst_i;
                        wb_d.delayslot = delayslot_i;
                        wb_d.hilo_we   = hilo_we_i;
                        wb_d.hilo_sel  = hilo_sel_i;
                    end else begin
                        lat_d.inst      = inst_i;
                        lat_d.pc        = pc_i;
                        lat_d.addr      = alu_result_i;
                        lat_d.sdata     = store_data_i;
                        lat_d.waddr     = reg_waddr_i;
                        lat_d.reg_we    = reg_we_i;
                        lat_d.delayslot = delayslot_i;
                        lat_d.hilo_we   = hilo_we_i;
                        lat_d.hilo_sel  = hilo_sel_i;
                        state_d         = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_i) begin
                    // A load granted in the flush cycle still returns one beat that must be eaten.
                    state_d = (dmem_gnt_i && lat_is_load) ? DRAIN : IDLE;
                end else if (dmem_gnt_i) begin
                    if (lat_is_load) begin
                        state_d = RESP;
                    end else begin
                        wb_d      = mem_wb;
                        wb_d.data = lat_q.addr;
                        state_d   = IDLE;
                    end
                end
            end
            RESP: begin
                if (flush_i) begin
                    state_d = dmem_rvalid_i ? IDLE : DRAIN;
                end else if (dmem_rvalid_i) begin
                    wb_d        = mem_wb;
                    wb_d.data   = extract(op_lat, lat_q.addr[1:0], dmem_rdata_i);
                    wb_d.reg_we = lat_q.reg_we;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (dmem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wb_q    <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            lat_q   <= lat_d;
        end
    end

    // Request fields are derived from the latched op and forced to zero outside REQ.
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = 32'd0;
        dmem_wdata_o = 32'd0;
        if (state_q == REQ) begin
            dmem_req_o  = 1'b1;
            dmem_we_o   = is_store(op_lat);
            dmem_addr_o = {lat_q.addr[31:2], 2'b00};
            case (op_lat)
                OP_SB: begin
                    dmem_be_o    = 4'b0001 << lat_q.addr[1:0];
                    dmem_wdata_o = {4{lat_q.sdata[7:0]}};
                end
                OP_SH: begin
                    dmem_be_o    = lat_q.addr[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata_o = {2{lat_q.sdata[15:0]}};
                end
                OP_SW: begin
                    dmem_be_o    = 4'b1111;
                    dmem_wdata_o = lat_q.sdata;
                end
                default: begin
                    // Loads fetch the whole word; lane selection happens on return.
                    dmem_be_o    = 4'b1111;
                    dmem_wdata_o = 32'd0;
                end
            endcase
        end
    end

    assign ex_ready_o       = (state_q == IDLE);
    assign data_o           = wb_q.data;
    assign inst_o           = wb_q.inst;
    assign pc_o             = wb_q.pc;
    assign reg_waddr_o      = wb_q.waddr;
    assign reg_we_o         = wb_q.reg_we;
    assign overflow_o       = wb_q.overflow;
    assign unaligned_addr_o = wb_q.unaligned;
    assign illegal_inst_o   = wb_q.illegal;
    assign delayslot_o      = wb_q.delayslot;
    assign hilo_we_o        = wb_q.hilo_we;
    assign hilo_sel_o       = wb_q.hilo_sel;

endmodule

// File: tb/tb_fairy_memory_stage.sv
// Purpose : directed bench for fairy_memory_stage with a writeback scoreboard.
// Latency : expected writebacks carry the cycle they must appear in.
// Backpr. : the bench plays the memory side, choosing gnt/rvalid timing per test.
module tb_fairy_memory_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid_i, ex_ready_o;
    logic [31:0] inst_i, pc_i, alu_result_i, store_data_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i, overflow_i, illegal_inst_i, delayslot_i, hilo_we_i, hilo_sel_i;
    logic        flush_i;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] data_o, inst_o, pc_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o, overflow_o, unaligned_addr_o, illegal_inst_o;
    logic        delayslot_o, hilo_we_o, hilo_sel_o;

    fairy_memory_stage dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .overflow_i(overflow_i),
        .illegal_inst_i(illegal_inst_i), .delayslot_i(delayslot_i),
        .hilo_we_i(hilo_we_i), .hilo_sel_i(hilo_sel_i), .flush_i(flush_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .data_o(data_o), .inst_o(inst_o), .pc_o(pc_o), .reg_waddr_o(reg_waddr_o),
        .reg_we_o(reg_we_o), .overflow_o(overflow_o), .unaligned_addr_o(unaligned_addr_o),
        .illegal_inst_o(illegal_inst_o), .delayslot_o(delayslot_o),
        .hilo_we_o(hilo_we_o), .hilo_sel_o(hilo_sel_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic        we, ovf, unal, ill, ds, hw, hs;
    } wbv_t;

    typedef struct {
        wbv_t w;
        int   c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    wbv_t act;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb act = {data_o, inst_o, pc_o, reg_waddr_o, reg_we_o, overflow_o,
                       unaligned_addr_o, illegal_inst_o, delayslot_o, hilo_we_o, hilo_sel_o};

    // Monitor: every non-bubble writeback must match the oldest expected entry, in its cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && act != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got %h at cycle %0d, want bubble", act, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (act !== e.w || cyc != e.c) begin
                    n_err++;
                    $display("FAIL wb: got %h at cycle %0d, want %h at cycle %0d", act, cyc, e.w, e.c);
                end
            end
        end
    end

    function automatic wbv_t mk(input logic [31:0] d, ins, p, input logic [4:0] wa,
                                input logic we, ovf, unal, ill, ds, hw, hs);
        return {d, ins, p, wa, we, ovf, unal, ill, ds, hw, hs};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, a, e);
        end
    endtask

    // Expected writeback appears at the edge after the current one.
    task automatic push(input wbv_t w);
        exp_t e;
        e.w = w;
        e.c = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ins, p, alu, sd, input logic [4:0] wa,
                         input logic we, ovf, ill, ds, hw, hs);
        inst_i = ins; pc_i = p; alu_result_i = alu; store_data_i = sd; reg_waddr_i = wa;
        reg_we_i = we; overflow_i = ovf; illegal_inst_i = ill; delayslot_i = ds;
        hilo_we_i = hw; hilo_sel_i = hs; ex_valid_i = 1'b1;
        chk("ex_ready_at_issue", {31'd0, ex_ready_o}, 32'd1);
        step();
        ex_valid_i = 1'b0; inst_i = '0; pc_i = '0; alu_result_i = '0; store_data_i = '0;
        reg_waddr_i = '0; reg_we_i = 1'b0; overflow_i = 1'b0; illegal_inst_i = 1'b0;
        delayslot_i = 1'b0; hilo_we_i = 1'b0; hilo_sel_i = 1'b0;
    endtask

    task automatic do_load(input string nm, input logic [31:0] ins, p, addr,
                           input logic [4:0] wa, input int gwait,
                           input logic [31:0] rdata, input logic [31:0] exp_d);
        issue(ins, p, addr, 32'd0, wa, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < gwait; i++) begin
            chk({nm, "_req_hold"}, {31'd0, dmem_req_o}, 32'd1);
            step();
        end
        chk({nm, "_req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({nm, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        chk({nm, "_we"}, {31'd0, dmem_we_o}, 32'd0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk({nm, "_req_after_gnt"}, {31'd0, dmem_req_o}, 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        push(mk(exp_d, ins, p, wa, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk({nm, "_ready_after"}, {31'd0, ex_ready_o}, 32'd1);
    endtask

    task automatic do_store(input string nm, input logic [31:0] ins, p, addr, sd,
                            input logic [3:0] be, input logic [31:0] wd);
        issue(ins, p, addr, sd, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({nm, "_req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({nm, "_we"}, {31'd0, dmem_we_o}, 32'd1);
        chk({nm, "_be"}, {28'd0, dmem_be_o}, {28'd0, be});
        chk({nm, "_wdata"}, dmem_wdata_o, wd);
        chk({nm, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
        dmem_gnt_i = 1'b1;
        push(mk(addr, ins, p, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        dmem_gnt_i = 1'b0;
        chk({nm, "_req_after_gnt"}, {31'd0, dmem_req_o}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; ex_valid_i = 1'b0; inst_i = '0; pc_i = '0; alu_result_i = '0;
        store_data_i = '0; reg_waddr_i = '0; reg_we_i = 1'b0; overflow_i = 1'b0;
        illegal_inst_i = 1'b0; delayslot_i = 1'b0; hilo_we_i = 1'b0; hilo_sel_i = 1'b0;
        flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        // Reset state
        #12;
        chk("rst_payload_nonzero", {31'd0, act != '0}, 32'd0);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_ready", {31'd0, ex_ready_o}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // ADDU passes through in one cycle with no memory request
        push(mk(32'h0000_1234, 32'h0085_1021, 32'h100, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h0085_1021, 32'h100, 32'h1234, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addu_no_req", {31'd0, dmem_req_o}, 32'd0);

        // MULT in a delay slot: hilo and delay-slot flags pass through
        push(mk(32'h55AA_0001, 32'h0085_0018, 32'h104, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        issue(32'h0085_0018, 32'h104, 32'h55AA_0001, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // ADD with overflow
        push(mk(32'h8000_0000, 32'h0085_1020, 32'h108, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h0085_1020, 32'h108, 32'h8000_0000, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // LW marked illegal: completes immediately, no memory access
        push(mk(32'h0000_3000, 32'h8CA4_0000, 32'h10C, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        issue(32'h8CA4_0000, 32'h10C, 32'h3000, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ill_no_req", {31'd0, dmem_req_o}, 32'd0);

        // Loads: lane extraction and sign/zero extension
        do_load("lb",  32'h80A2_0003, 32'h200, 32'h1003, 5'd2, 2, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lb1", 32'h80A2_0001, 32'h204, 32'h1001, 5'd2, 0, 32'h0000_7F00, 32'h0000_007F);
        do_load("lbu", 32'h90A3_0003, 32'h208, 32'h1003, 5'd3, 1, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("lh",  32'h84A5_0002, 32'h20C, 32'h1002, 5'd5, 0, 32'h8001_7777, 32'hFFFF_8001);
        do_load("lhu", 32'h94A6_0000, 32'h210, 32'h1000, 5'd6, 0, 32'h1234_F00F, 32'h0000_F00F);
        do_load("lw",  32'h8CA7_0000, 32'h214, 32'h3000, 5'd7, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Stores: byte enables and lane replication
        do_store("sh", 32'hA4A0_0002, 32'h300, 32'h2002, 32'hABCD_1234, 4'b1100, 32'h1234_1234);
        do_store("sb", 32'hA0A0_0001, 32'h304, 32'h2001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        do_store("sw", 32'hACA0_0004, 32'h308, 32'h2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Misaligned LW
`ifdef FAIRY_MEM_UNALIGNED_CHECK_EN
        push(mk(32'h0000_3001, 32'h8CA4_0001, 32'h400, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h8CA4_0001, 32'h400, 32'h3001, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("unal_no_req", {31'd0, dmem_req_o}, 32'd0);
`else
        do_load("lw_unal", 32'h8CA4_0001, 32'h400, 32'h3001, 5'd4, 0, 32'h1122_3344, 32'h1122_3344);
`endif

        // Flush while waiting for load data: drain the late beat
        issue(32'h8CA4_0000, 32'h500, 32'h3000, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_ready", {31'd0, ex_ready_o}, 32'd0);
            chk("drain_req", {31'd0, dmem_req_o}, 32'd0);
            step();
        end
        chk("drain_ready_last", {31'd0, ex_ready_o}, 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h9999_9999;
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk("drain_done_ready", {31'd0, ex_ready_o}, 32'd1);

        // Flush beats an accept in IDLE
        inst_i = 32'h0085_1021; alu_result_i = 32'h7777; reg_waddr_i = 5'd2; reg_we_i = 1'b1;
        ex_valid_i = 1'b1; flush_i = 1'b1;
        step();
        ex_valid_i = 1'b0; flush_i = 1'b0; inst_i = '0; alu_result_i = '0; reg_waddr_i = '0; reg_we_i = 1'b0;
        chk("flush_idle_ready", {31'd0, ex_ready_o}, 32'd1);
        chk("flush_idle_req", {31'd0, dmem_req_o}, 32'd0);

        // Flush in the same cycle a load is granted: one beat still returns
        issue(32'h84A5_0002, 32'h600, 32'h1002, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_gnt_i = 1'b1; flush_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0; flush_i = 1'b0;
        chk("flush_gnt_ld_ready", {31'd0, ex_ready_o}, 32'd0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk("flush_gnt_ld_done", {31'd0, ex_ready_o}, 32'd1);

        // Flush in the same cycle a store is granted: dropped silently
        issue(32'hACA0_0000, 32'h700, 32'h2000, 32'h1111_2222, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_gnt_i = 1'b1; flush_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0; flush_i = 1'b0;
        chk("flush_gnt_st_ready", {31'd0, ex_ready_o}, 32'd1);

        // Reset during REQ abandons the load; a stray response afterwards is ignored
        issue(32'h8CA4_0000, 32'h800, 32'h3000, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_req_before", {31'd0, dmem_req_o}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_req_async", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_payload_async", {31'd0, act != '0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0_BAD0;
        step();
        dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        chk("rst_stray_ready", {31'd0, ex_ready_o}, 32'd1);

        // Still functional afterwards
        push(mk(32'h0000_4321, 32'h0085_1021, 32'h900, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(32'h0085_1021, 32'h900, 32'h4321, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fairy_memory_stage.md
FAIRY_MEMORY_STAGE -- requirements
Module: fairy_memory_stage

Interface
REQ-001 SHALL have ports:
clk  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
ex_valid_i  in  1  execute stage presents an instruction
ex_ready_o  out  1  stage accepts an instruction this cycle
inst_i, pc_i, alu_result_i, store_data_i  in  32 each  instruction, PC, ALU result or effective address, store source
reg_waddr_i  in  5  destination register
reg_we_i, overflow_i, illegal_inst_i, delayslot_i, hilo_we_i, hilo_sel_i  in  1 each  execute-stage flags
flush_i  in  1  writeback exception or ERET; kills in-flight work
dmem_req_o  out  1  data-memory request
dmem_we_o  out  1  request is a store
dmem_be_o  out  4  byte enables
dmem_addr_o, dmem_wdata_o  out  32 each  word address with [1:0]=0, lane-replicated store data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load word
data_o, inst_o, pc_o  out  32 each  registered writeback payload
reg_waddr_o  out  5  registered destination
reg_we_o, overflow_o, unaligned_addr_o, illegal_inst_o, delayslot_o, hilo_we_o, hilo_sel_o  out  1 each  registered flags
REQ-002 SHALL have no parameters; ports listed are the complete interface.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, RESP, DRAIN; ex_ready_o=1 only in IDLE.
REQ-004 Decode SHALL use inst_i[31:26]: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011.
REQ-005 Unaligned SHALL be: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; never for byte ops.
REQ-006 IDLE accept (ex_valid_i and not flush_i) of non-memory op, or any op with overflow_i, illegal_inst_i or unaligned: SHALL load output registers at that edge (latency 1) with no memory request; data_o=alu_result_i.
REQ-007 Unaligned op SHALL output data_o=faulting address, unaligned_addr_o=1, reg_we_o=0.
REQ-008 IDLE accept of clean memory op SHALL latch the instruction, load output registers with a bubble, enter REQ.
REQ-009 REQ SHALL hold dmem_req_o=1 and request fields stable until dmem_gnt_i; store on gnt -> outputs loaded (data_o=address, reg_we_o=0), IDLE; load on gnt -> RESP.
REQ-010 RESP on dmem_rvalid_i SHALL load outputs with extracted data, go IDLE; outputs remain bubble while waiting.
REQ-011 Extraction SHALL be: LB/LBU byte addr[1:0] sign/zero-extended; LH/LHU halfword addr[1] sign/zero-extended; LW whole word.
REQ-012 Store lanes SHALL be: SB be=1<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?1100:0011, wdata={2{half}}; SW be=1111.
REQ-013 Bubble SHALL be all payload outputs zero (inst_o=0 decodes as NOP, reg_we_o=0).
REQ-014 flush_i SHALL win over every other event: outputs become bubble at that edge; IDLE/REQ -> IDLE, except a load granted same cycle -> DRAIN; RESP -> DRAIN unless rvalid same cycle (then IDLE, data discarded).
REQ-015 A store granted in the flush cycle SHALL still be performed by memory; stage drops it silently.
REQ-016 DRAIN SHALL discard the next dmem_rvalid_i beat, then go IDLE; ex_ready_o=0 throughout.
REQ-017 dmem_req_o SHALL be 0 in IDLE, RESP, DRAIN; at most one outstanding load.

Reset
REQ-018 reset_n low SHALL asynchronously force IDLE, all outputs and latched fields to 0, dmem_req_o=0.
REQ-019 Reset mid-transaction SHALL abandon it; responses arriving after release in IDLE SHALL be ignored.

Configuration
REQ-020 Macro FAIRY_MEM_UNALIGNED_CHECK_EN defined: REQ-005/007 active.
REQ-021 Macro undefined: unaligned_addr_o tied 0, no misalignment detection, lane select uses addr[1:0] as-is.

Verification
REQ-022 ADDU, alu_result=0x1234 -> next cycle data_o=0x00001234, reg_we_o=1, no dmem_req_o.
REQ-023 LB addr 0x1003, gnt after 2 cycles, rdata=0x80FFFFFF -> data_o=0xFFFFFF80 cycle after rvalid.
REQ-024 SH addr 0x2002, store_data=0xABCD1234 -> be=1100, wdata=0x12341234, addr=0x2000, reg_we_o=0.
REQ-025 LW addr 0x3001 (macro defined) -> no request, unaligned_addr_o=1, data_o=0x3001; undefined -> load issued.
REQ-026 LW granted, flush_i in RESP, rvalid 3 cycles later -> outputs bubble, ex_ready_o=0 until rvalid, then IDLE.
REQ-027 reset_n low during REQ -> dmem_req_o=0 immediately, all outputs 0.
